// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stall encodings, FSM states and helpers for the pipeline control unit.
package pipe_ctrl_pkg;

    localparam int unsigned RADDR_WIDTH = 5;
    localparam int unsigned ADDR_WIDTH  = 32;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [ADDR_WIDTH-1:0]  ZERO     = '0;

    // Stall vector bits: 0 pc, 1 if_id, 2 id_exe, 3 exe_mem, 4 mem_wb, 5 wb
    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [5:0] STALL_EXE      = 6'b001111;
    localparam logic [5:0] STALL_MEM      = 6'b011111;

    typedef enum logic {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } state_e;

    function automatic logic reg_match(input logic re,
                                       input logic [RADDR_WIDTH-1:0] raddr,
                                       input logic [RADDR_WIDTH-1:0] rd);
        return re && (raddr == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: the ID instruction reads the register a load in EXE
// is about to write. x0 never creates a dependency.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [RADDR_WIDTH-1:0] rs1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] rs2_raddr_i,
    input  logic                   rs1_re_i,
    input  logic                   rs2_re_i,
    input  logic                   inst_is_load_i,
    input  logic [RADDR_WIDTH-1:0] rd_i,
    output logic                   load_use_o
);

    assign load_use_o = inst_is_load_i && (rd_i != ZERO_REG) &&
                        (reg_match(rs1_re_i, rs1_raddr_i, rd_i) ||
                         reg_match(rs2_re_i, rs2_raddr_i, rd_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: MEM-wait FSM, stall/flush priority mux and stall counter.
// Optional bus watchdog is compiled in with `define PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] rs1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] rs2_raddr_i,
    input  logic                   rs1_re_i,
    input  logic                   rs2_re_i,
    input  logic                   inst_is_load_i,
    input  logic [RADDR_WIDTH-1:0] rd_i,
    input  logic                   exe_busy_i,
    input  logic                   jump_i,
    input  logic [ADDR_WIDTH-1:0]  jump_addr_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ack_i,
    output logic [5:0]             stall_o,
    output logic                   flush_jump_o,
    output logic                   jump_o,
    output logic [ADDR_WIDTH-1:0]  jump_addr_o,
    output logic [CNT_WIDTH-1:0]   stall_cnt_o,
    output logic                   timeout_err_o
);

    state_e               state_q;
    logic                 load_use;
    logic                 mem_wait;
    logic                 mem_stall;
    logic                 timeout_hit;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .rs1_raddr_i    (rs1_raddr_i),
        .rs2_raddr_i    (rs2_raddr_i),
        .rs1_re_i       (rs1_re_i),
        .rs2_re_i       (rs2_re_i),
        .inst_is_load_i (inst_is_load_i),
        .rd_i           (rd_i),
        .load_use_o     (load_use)
    );

    // An ack in the request cycle completes the access with no stall at all.
    assign mem_wait  = (state_q == StMemWait) ? !mem_ack_i : (mem_req_i && !mem_ack_i);
    assign mem_stall = mem_wait && !timeout_hit;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    logic [WaitW-1:0] wait_cnt_q;
    logic             timeout_err_q;

    assign timeout_hit = (state_q == StMemWait) && !mem_ack_i && (wait_cnt_q == WaitLast);

    // Held at zero in StRun, so it starts from zero on every entry to StMemWait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == StRun) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
    assign timeout_err_o         = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (mem_req_i && !mem_ack_i) begin
                        state_q <= StMemWait;
                    end
                end
                StMemWait: begin
                    if (mem_ack_i || timeout_hit) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // A jump held behind a MEM/EXE stall stays on jump_i and flushes on the first free cycle.
    always_comb begin
        stall_o      = STALL_NONE;
        flush_jump_o = 1'b0;
        jump_o       = 1'b0;
        jump_addr_o  = ZERO;
        if (!rst_i) begin
            if (mem_stall) begin
                stall_o = STALL_MEM;
            end else if (exe_busy_i) begin
                stall_o = STALL_EXE;
            end else if (jump_i) begin
                flush_jump_o = 1'b1;
                jump_o       = 1'b1;
                jump_addr_o  = jump_addr_i;
            end else if (load_use) begin
                stall_o = STALL_LOAD_USE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if ((stall_o[0] == STOP) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
